// File: rtl/eth_stream_pkg.sv
// Shared types for packet-granular stream arbitration: flit layout and arbiter FSM states.
package eth_stream_pkg;

    localparam int ETH_DATA_W = 64;
    localparam int ETH_KEEP_W = ETH_DATA_W / 8;

    typedef struct packed {
        logic [ETH_DATA_W-1:0] data;
        logic [ETH_KEEP_W-1:0] keep;
        logic                  last;
    } flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/eth_stream_pkt_arbiter_rr_pick.sv
// Round-robin priority encoder: first asserted req at or after ptr, wrapping modulo N.
// Purely combinational, 0-cycle latency; no backpressure of its own.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    // Rotate so that bit 0 is the request at ptr; the lowest set bit is the winner.
    assign w_rot = N'({req, req} >> ptr);

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_sum   = {1'b0, ptr} + {1'b0, w_off};
    assign gnt_idx = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N))
                                               : w_sum[IDX_W-1:0];
    assign gnt_vld = |req;

endmodule

// File: rtl/eth_stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter muxing NUM_IN flit streams onto one output.
// 0-cycle pass-through while locked, 1 arbitration bubble per packet; READY routed only to the granted input.
module eth_stream_pkt_arbiter
    import eth_stream_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_IN*DATA_W-1:0]     stream_in_DATA,
    input  logic [NUM_IN*DATA_W/8-1:0]   stream_in_KEEP,
    input  logic [NUM_IN-1:0]            stream_in_LAST,
    input  logic [NUM_IN-1:0]            stream_in_VALID,
    output logic [NUM_IN-1:0]            stream_in_READY,
    output logic [DATA_W-1:0]            stream_out_DATA,
    output logic [DATA_W/8-1:0]          stream_out_KEEP,
    output logic                         stream_out_LAST,
    output logic                         stream_out_VALID,
    input  logic                         stream_out_READY,
    output logic [$clog2(NUM_IN)-1:0]    grant_id,
    output logic                         busy,
    output logic [CNT_W-1:0]             pkt_count
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_IN);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [IDX_W-1:0] r_grant_id;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_vld;
    logic [CNT_W-1:0] r_pkt_count;

    logic [DATA_W-1:0] w_in_data [NUM_IN];
    logic [KEEP_W-1:0] w_in_keep [NUM_IN];
    logic              w_lock;
    logic              w_sel_vld;
    logic              w_sel_last;
    logic              w_accept;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign w_in_data[g] = stream_in_DATA[g*DATA_W +: DATA_W];
        assign w_in_keep[g] = stream_in_KEEP[g*KEEP_W +: KEEP_W];
    end

    rr_pick #(
        .N     (NUM_IN),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (stream_in_VALID),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick_idx),
        .gnt_vld (w_pick_vld)
    );

    // Reset gates the mux so a packet cut short by reset never leaks a beat.
    assign w_lock     = (r_state == LOCK) && !ap_rst;
    assign w_sel_vld  = stream_in_VALID[r_grant_id];
    assign w_sel_last = stream_in_LAST[r_grant_id];
    assign w_accept   = w_lock && w_sel_vld && stream_out_READY;

    always_comb begin
        w_next_state     = r_state;
        stream_in_READY  = '0;
        stream_out_DATA  = '0;
        stream_out_KEEP  = '0;
        stream_out_LAST  = 1'b0;
        stream_out_VALID = 1'b0;

        case (r_state)
            IDLE:    if (w_pick_vld) w_next_state = LOCK;
            LOCK:    if (w_accept && w_sel_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase

        if (w_lock) begin
            stream_out_DATA             = w_in_data[r_grant_id];
            stream_out_KEEP             = w_in_keep[r_grant_id];
            stream_out_LAST             = w_sel_last;
            stream_out_VALID            = w_sel_vld;
            stream_in_READY[r_grant_id] = stream_out_READY;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_pick_vld) begin
                r_grant_id <= w_pick_idx;
            end
            if (w_accept && w_sel_last) begin
                r_rr_ptr    <= (r_grant_id == IDX_W'(NUM_IN - 1)) ? '0 : r_grant_id + IDX_W'(1);
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end
        end
    end

    assign grant_id  = r_grant_id;
    assign busy      = w_lock;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_eth_stream_pkt_arbiter.sv
// Scoreboard bench: packets are staged per source, a packet-level round-robin model predicts
// the output order, and a monitor checks every accepted beat, READY routing, bubbles and counts.
module tb_eth_stream_pkt_arbiter;
    import eth_stream_pkg::*;

    localparam int NUM_IN = 4;
    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int CNT_W  = 32;

    logic                       ap_clk = 1'b0;
    logic                       ap_rst;
    logic [NUM_IN*DATA_W-1:0]   stream_in_DATA;
    logic [NUM_IN*KEEP_W-1:0]   stream_in_KEEP;
    logic [NUM_IN-1:0]          stream_in_LAST;
    logic [NUM_IN-1:0]          stream_in_VALID;
    logic [NUM_IN-1:0]          stream_in_READY;
    logic [DATA_W-1:0]          stream_out_DATA;
    logic [KEEP_W-1:0]          stream_out_KEEP;
    logic                       stream_out_LAST;
    logic                       stream_out_VALID;
    logic                       stream_out_READY;
    logic [1:0]                 grant_id;
    logic                       busy;
    logic [CNT_W-1:0]           pkt_count;

    always #5 ap_clk = ~ap_clk;

    eth_stream_pkt_arbiter #(
        .NUM_IN (NUM_IN),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .stream_in_DATA   (stream_in_DATA),
        .stream_in_KEEP   (stream_in_KEEP),
        .stream_in_LAST   (stream_in_LAST),
        .stream_in_VALID  (stream_in_VALID),
        .stream_in_READY  (stream_in_READY),
        .stream_out_DATA  (stream_out_DATA),
        .stream_out_KEEP  (stream_out_KEEP),
        .stream_out_LAST  (stream_out_LAST),
        .stream_out_VALID (stream_out_VALID),
        .stream_out_READY (stream_out_READY),
        .grant_id         (grant_id),
        .busy             (busy),
        .pkt_count        (pkt_count)
    );

    typedef struct {
        flit_t f;
        int    src;
    } exp_t;

    exp_t  exp_q [$];
    flit_t src_q [NUM_IN][$];
    flit_t stg_q [NUM_IN][$];
    int    stg_len [NUM_IN][$];
    int    stg_cur [NUM_IN];
    bit    src_mid [NUM_IN];
    bit    acc     [NUM_IN];
    int    m_ptr    = 0;
    int    exp_pkts = 0;
    int    beats    = 0;
    int    checks   = 0;
    int    passes   = 0;
    int    rdy_mode = 0;
    bit    gap_en   = 1'b0;
    bit    all_vld  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic stage_flit(input int s, input logic [63:0] d, input logic [7:0] k, input bit l);
        flit_t f;
        f.data = d;
        f.keep = k;
        f.last = l;
        stg_q[s].push_back(f);
        stg_cur[s]++;
        if (l) begin
            stg_len[s].push_back(stg_cur[s]);
            stg_cur[s] = 0;
        end
    endtask

    // All staged packets become visible together, so every arbitration sees exactly the
    // sources that still hold packets: next winner is the first such source from m_ptr.
    task automatic commit();
        int   off [NUM_IN];
        int   left;
        int   s;
        int   n;
        exp_t e;
        left = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            off[i] = 0;
            left  += stg_len[i].size();
        end
        while (left > 0) begin
            for (int d = 0; d < NUM_IN; d++) begin
                s = (m_ptr + d) % NUM_IN;
                if (stg_len[s].size() > 0) begin
                    n = stg_len[s].pop_front();
                    for (int k = 0; k < n; k++) begin
                        e.f   = stg_q[s][off[s] + k];
                        e.src = s;
                        exp_q.push_back(e);
                    end
                    off[s] += n;
                    m_ptr   = (s + 1) % NUM_IN;
                    left--;
                    break;
                end
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            for (int k = 0; k < stg_q[i].size(); k++) src_q[i].push_back(stg_q[i][k]);
            stg_q[i].delete();
            stg_cur[i] = 0;
        end
    endtask

    task automatic do_reset(input int n);
        ap_rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_IN; i++) begin
            src_q[i].delete();
            stg_q[i].delete();
            stg_len[i].delete();
            stg_cur[i] = 0;
            src_mid[i] = 1'b0;
            acc[i]     = 1'b0;
        end
        m_ptr    = 0;
        exp_pkts = 0;
        repeat (n) tick();
        ap_rst = 1'b0;
    endtask

    function automatic bit sources_busy();
        for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() > 0) return 1'b1;
        return exp_q.size() > 0;
    endfunction

    task automatic drain(input int max_cyc);
        int cnt;
        cnt = 0;
        while (sources_busy() && cnt < max_cyc) begin
            tick();
            cnt++;
        end
        if (sources_busy()) begin
            checks++;
            $display("FAIL drain_timeout: %0d flits still expected after %0d cycles, expected 0",
                     exp_q.size(), max_cyc);
            do_reset(2);
        end
    endtask

    // Source driver: presents queue heads at the falling edge, records handshakes just before the rising edge.
    initial begin
        logic [NUM_IN*DATA_W-1:0] d;
        logic [NUM_IN*KEEP_W-1:0] k;
        logic [NUM_IN-1:0]        l;
        logic [NUM_IN-1:0]        v;
        bit                       tog;
        tog = 1'b0;
        forever begin
            @(negedge ap_clk);
            for (int i = 0; i < NUM_IN; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    src_mid[i] = !src_q[i][0].last;
                    void'(src_q[i].pop_front());
                end
                acc[i] = 1'b0;
            end
            d = '0;
            k = '0;
            l = '0;
            v = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (src_q[i].size() > 0) begin
                    d[i*DATA_W +: DATA_W] = src_q[i][0].data;
                    k[i*KEEP_W +: KEEP_W] = src_q[i][0].keep;
                    l[i]                  = src_q[i][0].last;
                    v[i] = !(gap_en && src_mid[i] && $urandom_range(0, 3) == 0);
                end else if (all_vld) begin
                    v[i] = 1'b1;
                end
            end
            stream_in_DATA  = d;
            stream_in_KEEP  = k;
            stream_in_LAST  = l;
            stream_in_VALID = v;
            case (rdy_mode)
                0:       stream_out_READY = 1'b1;
                1:       stream_out_READY = 1'($urandom_range(0, 1));
                default: begin
                    tog              = !tog;
                    stream_out_READY = tog;
                end
            endcase
            #3;
            for (int i = 0; i < NUM_IN; i++) acc[i] = stream_in_VALID[i] && stream_in_READY[i];
        end
    end

    // Monitor: compares every accepted output beat against the scoreboard head.
    initial begin
        bit                prev_last;
        exp_t              e;
        logic [NUM_IN-1:0] rdy_exp;
        prev_last = 1'b0;
        forever begin
            @(negedge ap_clk);
            #3;
            if (ap_rst) begin
                chk("rst_in_ready", stream_in_READY, 0);
                chk("rst_out_valid", stream_out_VALID, 0);
                chk("rst_out_data", stream_out_DATA, 0);
                chk("rst_out_keep_last", {stream_out_KEEP, stream_out_LAST}, 0);
                chk("rst_busy", busy, 0);
                prev_last = 1'b0;
            end else begin
                chk("pkt_count", pkt_count, exp_pkts);
                if (prev_last) chk("bubble_after_last", {busy, stream_out_VALID}, 0);
                prev_last = 1'b0;
                rdy_exp = '0;
                if (busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL busy_without_packet: busy=1, expected 0 with nothing queued");
                    end else begin
                        rdy_exp[exp_q[0].src] = stream_out_READY;
                    end
                end else begin
                    chk("idle_out_valid", stream_out_VALID, 0);
                end
                chk("in_ready_routing", stream_in_READY, rdy_exp);
                if (stream_out_VALID && stream_out_READY) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_beat: data 0x%0h, expected no beat", stream_out_DATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", stream_out_DATA, e.f.data);
                        chk("beat_keep", stream_out_KEEP, e.f.keep);
                        chk("beat_last", stream_out_LAST, e.f.last);
                        chk("beat_grant_id", grant_id, e.src);
                        beats++;
                        if (e.f.last) begin
                            exp_pkts++;
                            prev_last = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int len;
        int b0;
        int cnt;
        ap_rst           = 1'b1;
        all_vld          = 1'b1;
        stream_in_DATA   = '0;
        stream_in_KEEP   = '0;
        stream_in_LAST   = '0;
        stream_in_VALID  = '0;
        stream_out_READY = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            stg_cur[i] = 0;
            src_mid[i] = 1'b0;
            acc[i]     = 1'b0;
        end

        // Reset held 3 cycles with every input requesting.
        repeat (2) tick();
        @(negedge ap_clk);
        #3;
        chk("t1_pkt_count", pkt_count, 0);
        chk("t1_in_ready", stream_in_READY, 0);
        chk("t1_out_valid", stream_out_VALID, 0);
        chk("t1_busy", busy, 0);
        tick();
        ap_rst  = 1'b0;
        all_vld = 1'b0;
        tick();

        // Two-flit packet on input 0: one idle bubble, then pass-through.
        stage_flit(0, 64'h0100000100030000, 8'hff, 1'b0);
        stage_flit(0, 64'h5073930200000000, 8'h0f, 1'b1);
        commit();
        @(negedge ap_clk);
        #3;
        chk("t2_bubble_valid", stream_out_VALID, 0);
        chk("t2_bubble_busy", busy, 0);
        @(negedge ap_clk);
        #3;
        chk("t2_first_valid", stream_out_VALID, 1);
        chk("t2_grant_id", grant_id, 0);
        tick();
        drain(50);
        chk("t2_pkt_count", pkt_count, 1);

        // Continuous single-flit packets from all inputs.
        do_reset(2);
        for (int s = 0; s < NUM_IN; s++)
            for (int p = 0; p < 4; p++) stage_flit(s, {32'(s), 32'(p)}, 8'(8'h10 + s), 1'b1);
        commit();
        repeat (16) @(posedge ap_clk);
        #1;
        chk("t3_pkt_count_16cyc", pkt_count, 8);
        drain(100);

        // Input 1 three-flit packet with input 2 waiting; downstream READY toggling.
        rdy_mode = 2;
        for (int k = 0; k < 3; k++) stage_flit(1, 64'hA1A1_0000_0000_0000 + 64'(k), 8'hff, k == 2);
        stage_flit(2, 64'hB2B2_B2B2_B2B2_B2B2, 8'h3c, 1'b1);
        commit();
        drain(100);

        // Randomized rounds.
        rdy_mode = 1;
        gap_en   = 1'b1;
        for (int r = 0; r < 10; r++) begin
            for (int s = 0; s < NUM_IN; s++) begin
                n = $urandom_range(0, 3);
                for (int p = 0; p < n; p++) begin
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++)
                        stage_flit(s, {$urandom, $urandom}, 8'($urandom), k == len - 1);
                end
            end
            commit();
            drain(3000);
        end

        // Reset during flit 2 of 3, then input 0 must beat input 3.
        rdy_mode = 0;
        gap_en   = 1'b0;
        for (int k = 0; k < 3; k++) stage_flit(1, 64'hC0DE_0000_0000_0000 + 64'(k), 8'hff, k == 2);
        commit();
        b0  = beats;
        cnt = 0;
        while (beats < b0 + 1 && cnt < 50) begin
            tick();
            cnt++;
        end
        if (beats < b0 + 1) begin
            checks++;
            $display("FAIL t6_first_flit: %0d beats seen, expected %0d", beats - b0, 1);
        end
        do_reset(2);
        @(negedge ap_clk);
        #3;
        chk("t6_after_rst_busy", busy, 0);
        chk("t6_after_rst_valid", stream_out_VALID, 0);
        tick();
        stage_flit(3, 64'h3333_3333_3333_3333, 8'h01, 1'b1);
        stage_flit(0, 64'h0000_0000_0000_0A0A, 8'h80, 1'b1);
        commit();
        drain(50);
        chk("t6_pkt_count", pkt_count, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
